// File: rtl/framebuffer_writer.sv
// RGB565 pixel stream to PSRAM write port: packs up to 4 pixels per 64-bit word
// inside a column/page window, with byte mask and a window-wrapping cursor.
module framebuffer_writer #(
  parameter logic [20:0] BASE_ADDR    = 21'd0,
  parameter int          STRIDE_WORDS = 320,
  parameter int          COORD_W      = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_win_x0,
  input  logic [COORD_W-1:0] i_win_x1,
  input  logic [COORD_W-1:0] i_win_y0,
  input  logic [COORD_W-1:0] i_win_y1,
  input  logic               i_win_set,
  input  logic               i_pixel_valid,
  input  logic [15:0]        i_pixel_data,
  output logic               o_pixel_ready,
  output logic               o_busy,
  output logic               o_psram_write_req,
  input  logic               i_psram_write_gnt,
  output logic [20:0]        o_psram_write_addr,
  output logic [63:0]        o_psram_write_data,
  output logic [7:0]         o_psram_write_data_mask,
  output logic [1:0]         o_dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_SETUP = 2'd2;
  localparam logic [20:0] STRIDE  = 21'(STRIDE_WORDS);

  logic [1:0]         state;
  logic [COORD_W-1:0] win_x0, win_x1, win_y0, win_y1;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [20:0]        row_base, row_base0;
  logic [63:0]        acc_data;
  logic [7:0]         acc_mask;
  logic [20:0]        acc_addr;
  logic               set_pending;

  logic               win_valid;
  logic               set_req;
  logic               accept;
  logic [1:0]         lane;
  logic               last_col;
  logic               flush_px;
  logic [20:0]        pix_addr;
  logic [63:0]        merged_data;
  logic [7:0]         merged_mask;

  // Pixel handshake: a pixel transfers on a rising clock edge where
  // i_pixel_valid && o_pixel_ready; the PSRAM request is held until the
  // single-cycle i_psram_write_gnt, which consumes it.
  assign win_valid     = (win_x1 >= win_x0) && (win_y1 >= win_y0);
  assign set_req       = i_win_set | set_pending;
  assign o_pixel_ready = (state == ST_IDLE) && !set_req;
  assign accept        = i_pixel_valid && o_pixel_ready;
  assign lane          = cur_x[1:0];
  assign last_col      = (cur_x == win_x1);
  assign flush_px      = accept && win_valid && ((lane == 2'd3) || last_col);
  assign pix_addr      = BASE_ADDR + row_base + 21'(cur_x >> 2);
  assign o_busy        = set_pending;
  assign o_dbg_state   = state;

  always_comb begin
    merged_data = acc_data;
    merged_mask = acc_mask;
    merged_data[{lane, 4'b0000} +: 16] = i_pixel_data;
    merged_mask[{lane, 1'b0} +: 2]     = 2'b00;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                   <= ST_IDLE;
      win_x0                  <= '0;
      win_x1                  <= '0;
      win_y0                  <= '0;
      win_y1                  <= '0;
      cur_x                   <= '0;
      cur_y                   <= '0;
      row_base                <= '0;
      row_base0               <= '0;
      acc_data                <= '0;
      acc_mask                <= 8'hFF;
      acc_addr                <= '0;
      set_pending             <= 1'b0;
      o_psram_write_req       <= 1'b0;
      o_psram_write_addr      <= '0;
      o_psram_write_data      <= '0;
      o_psram_write_data_mask <= 8'hFF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (set_req) begin
            // A partial word belongs to the old window: write it out before setup.
            if (acc_mask != 8'hFF) begin
              o_psram_write_addr      <= acc_addr;
              o_psram_write_data      <= acc_data;
              o_psram_write_data_mask <= acc_mask;
              o_psram_write_req       <= 1'b1;
              state                   <= ST_REQ;
            end else begin
              state <= ST_SETUP;
            end
          end else if (accept && win_valid) begin
            acc_data <= merged_data;
            acc_mask <= merged_mask;
            acc_addr <= pix_addr;
            if (last_col) begin
              cur_x <= win_x0;
              if (cur_y == win_y1) begin
                cur_y    <= win_y0;
                row_base <= row_base0;
              end else begin
                cur_y    <= cur_y + 1'b1;
                row_base <= row_base + STRIDE;
              end
            end else begin
              cur_x <= cur_x + 1'b1;
            end
            if (flush_px) begin
              o_psram_write_addr      <= pix_addr;
              o_psram_write_data      <= merged_data;
              o_psram_write_data_mask <= merged_mask;
              o_psram_write_req       <= 1'b1;
              state                   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (i_psram_write_gnt) begin
            o_psram_write_req <= 1'b0;
            acc_data          <= '0;
            acc_mask          <= 8'hFF;
            state             <= set_req ? ST_SETUP : ST_IDLE;
          end
        end
        ST_SETUP: begin
          cur_x       <= win_x0;
          cur_y       <= win_y0;
          row_base    <= 21'(win_y0) * STRIDE;
          row_base0   <= 21'(win_y0) * STRIDE;
          set_pending <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Placed last so a pulse landing in SETUP stays pending for another setup.
      if (i_win_set) begin
        win_x0      <= i_win_x0;
        win_x1      <= i_win_x1;
        win_y0      <= i_win_y0;
        win_y1      <= i_win_y1;
        set_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: directed and random windows against a pixel-index
// reference model that predicts every PSRAM write (address, bytes, mask).
module tb_framebuffer_writer;
  localparam int          STRIDE = 320;
  localparam logic [20:0] BASE   = 21'd0;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [10:0] i_win_x0, i_win_x1, i_win_y0, i_win_y1;
  logic        i_win_set;
  logic        i_pixel_valid;
  logic [15:0] i_pixel_data;
  logic        o_pixel_ready;
  logic        o_busy;
  logic        o_psram_write_req;
  logic        i_psram_write_gnt;
  logic [20:0] o_psram_write_addr;
  logic [63:0] o_psram_write_data;
  logic [7:0]  o_psram_write_data_mask;
  logic [1:0]  o_dbg_state;

  framebuffer_writer #(.BASE_ADDR(BASE), .STRIDE_WORDS(STRIDE), .COORD_W(11)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_win_x0(i_win_x0), .i_win_x1(i_win_x1), .i_win_y0(i_win_y0), .i_win_y1(i_win_y1),
    .i_win_set(i_win_set), .i_pixel_valid(i_pixel_valid), .i_pixel_data(i_pixel_data),
    .o_pixel_ready(o_pixel_ready), .o_busy(o_busy),
    .o_psram_write_req(o_psram_write_req), .i_psram_write_gnt(i_psram_write_gnt),
    .o_psram_write_addr(o_psram_write_addr), .o_psram_write_data(o_psram_write_data),
    .o_psram_write_data_mask(o_psram_write_data_mask), .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected writes, packed {addr[20:0], data[63:0], mask[7:0]}.
  logic [92:0] exp_q[$];

  int          mx0, mx1, my0, my1, mp;
  logic [63:0] m_data;
  logic [7:0]  m_mask;
  logic [20:0] m_addr;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] bytes_en(input logic [63:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) d[b*8 +: 8] = 8'h00;
    return d;
  endfunction

  task automatic model_clear_acc();
    m_data = '0;
    m_mask = 8'hFF;
  endtask

  task automatic model_reset();
    mx0 = 0; mx1 = 0; my0 = 0; my1 = 0; mp = 0;
    model_clear_acc();
  endtask

  // Pixel p of a window scans raster order: x = x0 + p mod w, y = y0 + (p div w) mod h.
  task automatic model_pixel(input logic [15:0] pix);
    int w, h, x, y, ln;
    if (mx1 < mx0 || my1 < my0) return;
    w = mx1 - mx0 + 1;
    h = my1 - my0 + 1;
    x = mx0 + mp % w;
    y = my0 + (mp / w) % h;
    mp++;
    ln = x % 4;
    m_addr = 21'(int'(BASE) + y * STRIDE + x / 4);
    m_data[ln*16 +: 16] = pix;
    m_mask[ln*2 +: 2]   = 2'b00;
    if (ln == 3 || x == mx1) begin
      exp_q.push_back({m_addr, m_data, m_mask});
      model_clear_acc();
    end
  endtask

  task automatic model_set(input int x0, input int x1, input int y0, input int y1);
    if (m_mask != 8'hFF) begin
      exp_q.push_back({m_addr, m_data, m_mask});
      model_clear_acc();
    end
    mx0 = x0; mx1 = x1; my0 = y0; my1 = y1; mp = 0;
  endtask

  task automatic set_window(input int x0, input int x1, input int y0, input int y1, input bit with_pix);
    @(negedge i_clk);
    i_psram_write_gnt = 1'b0;
    i_win_x0 = 11'(x0); i_win_x1 = 11'(x1);
    i_win_y0 = 11'(y0); i_win_y1 = 11'(y1);
    i_win_set     = 1'b1;
    i_pixel_valid = with_pix;
    i_pixel_data  = 16'($urandom);
    #1;
    check("ready_low_on_set", 96'(o_pixel_ready), 96'(1'b0));
    @(posedge i_clk);
    #1;
    i_win_set     = 1'b0;
    i_pixel_valid = 1'b0;
    model_set(x0, x1, y0, y1);
  endtask

  // Feeds n pixels and services every write request; gnt_delay < 0 returns
  // at the first request without granting it.
  task automatic run_stream(input int n, input int gnt_delay, input bit inc_data);
    int sent, wait_cnt;
    bit in_req, gnt_prev, done;
    logic [92:0] held, e;
    logic [15:0] pix;
    sent = 0; wait_cnt = 0; in_req = 0; gnt_prev = 0; done = 0;
    held = '0;
    pix = inc_data ? 16'd1 : 16'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge i_clk);
      i_psram_write_gnt = 1'b0;
      i_pixel_valid     = 1'b0;
      if (gnt_prev) check("one_write_per_gnt", 96'(o_psram_write_req), 96'(1'b0));
      gnt_prev = 0;
      if (o_psram_write_req) begin
        if (!in_req) begin
          in_req = 1; wait_cnt = 0;
          held = {o_psram_write_addr, o_psram_write_data, o_psram_write_data_mask};
          if (exp_q.size() == 0) begin
            check("unexpected_write_req", 96'(o_psram_write_req), 96'(1'b0));
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 96'(o_psram_write_addr), 96'(e[92:72]));
            check("wr_mask", 96'(o_psram_write_data_mask), 96'(e[7:0]));
            check("wr_data", 96'(bytes_en(o_psram_write_data, e[7:0])), 96'(bytes_en(e[71:8], e[7:0])));
          end
          if (gnt_delay < 0) begin
            done = 1;
            break;
          end
        end else begin
          check("req_hold_stable",
                96'({o_psram_write_addr, o_psram_write_data, o_psram_write_data_mask}), 96'(held));
        end
        check("ready_low_in_req", 96'(o_pixel_ready), 96'(1'b0));
        if (wait_cnt == gnt_delay) begin
          i_psram_write_gnt = 1'b1;
          gnt_prev = 1;
          in_req = 0;
        end
        wait_cnt++;
      end else begin
        in_req = 0;
        if (sent >= n && !o_busy && exp_q.size() == 0) begin
          done = 1;
          break;
        end
        if (sent < n) begin
          i_pixel_valid = 1'b1;
          i_pixel_data  = pix;
          if (o_pixel_ready) begin
            model_pixel(pix);
            sent++;
            pix = inc_data ? 16'(sent + 1) : 16'($urandom);
          end
        end
      end
    end
    check("stream_done", 96'(done), 96'(1'b1));
    if (gnt_delay >= 0) check("exp_q_drained", 96'(exp_q.size()), 96'(0));
  endtask

  initial begin
    int x0, y0, x1, y1;
    i_rst = 1'b1;
    i_win_x0 = '0; i_win_x1 = '0; i_win_y0 = '0; i_win_y1 = '0;
    i_win_set = 1'b0; i_pixel_valid = 1'b0; i_pixel_data = '0;
    i_psram_write_gnt = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_req",   96'(o_psram_write_req), 96'(1'b0));
    check("rst_addr",  96'(o_psram_write_addr), 96'(21'd0));
    check("rst_data",  96'(o_psram_write_data), 96'(64'd0));
    check("rst_mask",  96'(o_psram_write_data_mask), 96'(8'hFF));
    check("rst_busy",  96'(o_busy), 96'(1'b0));
    i_rst = 1'b0;
    #1;
    check("rst_ready", 96'(o_pixel_ready), 96'(1'b1));

    // Full line of 8 pixels, counting data 1..8.
    set_window(0, 7, 0, 0, 0);
    run_stream(8, 1, 1);

    // Offset window with a pixel offered alongside the set pulse.
    set_window(2, 5, 1, 1, 1);
    run_stream(4, 0, 0);

    // Two-line window wraps back to its origin; the 13th pixel stays partial.
    set_window(0, 3, 0, 1, 0);
    run_stream(12, 2, 0);
    run_stream(1, 0, 0);

    // Slow grant: request and payload must hold.
    set_window(0, 3, 5, 5, 0);
    run_stream(4, 5, 0);

    // New window with a partial word pending.
    set_window(0, 7, 0, 0, 0);
    run_stream(2, 0, 0);
    set_window(4, 7, 2, 2, 0);
    @(negedge i_clk);
    check("busy_after_set", 96'(o_busy), 96'(1'b1));
    run_stream(4, 1, 0);

    // Second set while the flush request is outstanding.
    set_window(0, 7, 0, 0, 0);
    run_stream(3, 0, 0);
    set_window(8, 15, 3, 3, 0);
    set_window(12, 15, 4, 4, 0);
    run_stream(4, 2, 0);

    // Inverted window swallows pixels without writing.
    set_window(6, 2, 0, 0, 0);
    run_stream(5, 0, 0);

    // Random windows.
    for (int t = 0; t < 8; t++) begin
      x0 = $urandom_range(0, 1270);
      x1 = x0 + $urandom_range(0, 9);
      y0 = $urandom_range(0, 2040);
      y1 = y0 + $urandom_range(0, 3);
      set_window(x0, x1, y0, y1, $urandom_range(0, 1) == 1);
      run_stream($urandom_range(1, 30), $urandom_range(0, 3), 0);
    end

    // Reset while a request is waiting; a grant in the reset cycle is ignored.
    set_window(0, 3, 0, 0, 0);
    run_stream(4, -1, 0);
    i_rst = 1'b1;
    i_psram_write_gnt = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rstreq_req",  96'(o_psram_write_req), 96'(1'b0));
    check("rstreq_mask", 96'(o_psram_write_data_mask), 96'(8'hFF));
    check("rstreq_busy", 96'(o_busy), 96'(1'b0));
    i_rst = 1'b0;
    i_psram_write_gnt = 1'b0;
    exp_q.delete();
    model_reset();
    run_stream(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
